// File: rtl/imem_stream_loader.sv
// Streams big-endian bytes into 32-bit instruction-memory writes while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to append a 4-byte running-sum check after the last word.
//
// state | meaning
// IDLE  | waiting for Start; CPU runs
// LOAD  | collecting 4 bytes of the current word
// WRITE | one-cycle write strobe to instruction memory
// CHECK | collecting the 4-byte expected checksum (checksum build only)
// DONE  | one-cycle completion pulse; CPU still held
module imem_stream_loader #(
   parameter int          WORD_ADDR_W = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic [WORD_ADDR_W:0]   NumWords,
   input  logic [7:0]             ByteIn,
   input  logic                   ByteValid,
   output logic                   ByteReady,
   output logic                   MemWrite,
   output logic [31:0]            MemAddress,
   output logic [31:0]            MemWriteData,
   output logic                   CpuHold,
   output logic                   Busy,
   output logic                   Done,
   output logic                   ChecksumErr
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK = 3'd4,
`endif
      DONE  = 3'd3
   } stateT;

   localparam logic [WORD_ADDR_W:0] MaxWords = {1'b1, {WORD_ADDR_W{1'b0}}};
   localparam logic [WORD_ADDR_W:0] OneWord  = {{WORD_ADDR_W{1'b0}}, 1'b1};

   stateT                state;
   stateT                nextState;
   logic [1:0]           byteCnt;
   logic [WORD_ADDR_W:0] wordIdx;
   logic [WORD_ADDR_W:0] numWordsQ;
   logic [31:0]          shiftReg;
   logic [31:0]          memAddrQ;
   logic [31:0]          memDataQ;
   logic                 byteXfer;
   logic                 wordComplete;
   logic                 lastWord;
   logic                 startAccept;
   logic [31:0]          assembled;

   assign byteXfer     = ByteValid && ByteReady;
   assign wordComplete = byteXfer && (byteCnt == 2'd3);
   assign assembled    = {shiftReg[23:0], ByteIn};
   assign lastWord     = ((wordIdx + OneWord) == numWordsQ);
   assign startAccept  = (state == IDLE) && Start;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (Start) begin
               if (NumWords == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  nextState = CHECK;
`else
                  nextState = DONE;
`endif
               end else begin
                  nextState = LOAD;
               end
            end
         end
         LOAD:  if (wordComplete) nextState = WRITE;
         WRITE: begin
            if (lastWord) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               nextState = CHECK;
`else
               nextState = DONE;
`endif
            end else begin
               nextState = LOAD;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: if (wordComplete) nextState = DONE;
`endif
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      ByteReady = 1'b0;
      MemWrite  = 1'b0;
      CpuHold   = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      case (state)
         IDLE: ;
         LOAD: begin
            ByteReady = 1'b1;
            CpuHold   = 1'b1;
            Busy      = 1'b1;
         end
         WRITE: begin
            MemWrite = 1'b1;
            CpuHold  = 1'b1;
            Busy     = 1'b1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            ByteReady = 1'b1;
            CpuHold   = 1'b1;
            Busy      = 1'b1;
         end
`endif
         DONE: begin
            Done    = 1'b1;
            CpuHold = 1'b1;
            Busy    = 1'b1;
         end
         default: ;
      endcase
   end

   // Address/data are captured on the 4th byte so they are stable for the
   // whole WRITE cycle and simply hold afterwards.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         byteCnt   <= 2'd0;
         wordIdx   <= '0;
         numWordsQ <= '0;
         shiftReg  <= 32'h0;
         memAddrQ  <= 32'h0;
         memDataQ  <= 32'h0;
      end else begin
         if (startAccept) begin
            byteCnt   <= 2'd0;
            wordIdx   <= '0;
            shiftReg  <= 32'h0;
            numWordsQ <= (NumWords > MaxWords) ? MaxWords : NumWords;
         end
         if (byteXfer) begin
            shiftReg <= assembled;
            byteCnt  <= byteCnt + 2'd1;
         end
         if ((state == LOAD) && wordComplete) begin
            memAddrQ <= BASE_ADDR + (32'(wordIdx) << 2);
            memDataQ <= assembled;
         end
         if (state == WRITE) wordIdx <= wordIdx + OneWord;
      end
   end

   assign MemAddress   = memAddrQ;
   assign MemWriteData = memDataQ;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] runSum;
   logic        sumErr;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         runSum <= 32'h0;
         sumErr <= 1'b0;
      end else begin
         if (startAccept) begin
            runSum <= 32'h0;
            sumErr <= 1'b0;
         end
         if (state == WRITE) runSum <= runSum + memDataQ;
         if ((state == CHECK) && wordComplete) sumErr <= (assembled != runSum);
      end
   end

   assign ChecksumErr = sumErr;
`else
   assign ChecksumErr = 1'b0;
`endif

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed self-checking bench for imem_stream_loader; a second instance checks address wrap.
// Checksum steps run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_stream_loader;
   localparam int W = 8;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          Start = 1'b0;
   logic [W:0]    NumWords = '0;
   logic [7:0]    ByteIn = 8'h00;
   logic          ByteValid = 1'b0;

   logic          aByteReady, aMemWrite, aCpuHold, aBusy, aDone, aChecksumErr;
   logic [31:0]   aMemAddress, aMemWriteData;
   logic          bByteReady, bMemWrite, bCpuHold, bBusy, bDone, bChecksumErr;
   logic [31:0]   bMemAddress, bMemWriteData;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            doneCount = 0;
   int            rdyDuringWr = 0;
   logic [31:0]   aAddrQ[$];
   logic [31:0]   aDataQ[$];
   int            aCycQ[$];
   logic [31:0]   bAddrQ[$];
   logic [31:0]   words[$];
   int            dCyc;
   logic          errAtDone;

   imem_stream_loader #(.WORD_ADDR_W(W), .BASE_ADDR(32'h0000_0000)) dutA (
      .Clk(Clk), .Reset(Reset), .Start(Start), .NumWords(NumWords),
      .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(aByteReady),
      .MemWrite(aMemWrite), .MemAddress(aMemAddress), .MemWriteData(aMemWriteData),
      .CpuHold(aCpuHold), .Busy(aBusy), .Done(aDone), .ChecksumErr(aChecksumErr)
   );

   imem_stream_loader #(.WORD_ADDR_W(W), .BASE_ADDR(32'hFFFF_FFF8)) dutB (
      .Clk(Clk), .Reset(Reset), .Start(Start), .NumWords(NumWords),
      .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(bByteReady),
      .MemWrite(bMemWrite), .MemAddress(bMemAddress), .MemWriteData(bMemWriteData),
      .CpuHold(bCpuHold), .Busy(bBusy), .Done(bDone), .ChecksumErr(bChecksumErr)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk) begin
      if (aMemWrite) begin
         aAddrQ.push_back(aMemAddress);
         aDataQ.push_back(aMemWriteData);
         aCycQ.push_back(cyc);
      end
      if (bMemWrite) bAddrQ.push_back(bMemAddress);
      if (aDone) doneCount++;
      if (aMemWrite && aByteReady) rdyDuringWr++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clearLog();
      aAddrQ.delete();
      aDataQ.delete();
      aCycQ.delete();
      bAddrQ.delete();
      doneCount = 0;
      rdyDuringWr = 0;
   endtask

   task automatic pulseStart(input int n);
      Start = 1'b1;
      NumWords = n[W:0];
      @(posedge Clk); #1;
      Start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      int n;
      n = 0;
      ByteIn = b;
      ByteValid = 1'b1;
      @(negedge Clk);
      while (!aByteReady && n < 100) begin
         n++;
         @(negedge Clk);
      end
      if (n >= 100) chk("byte_ready_timeout", 32'(n), 32'd0);
      @(posedge Clk); #1;
   endtask

   task automatic sendWord(input logic [31:0] w, input bit gap);
      for (int i = 0; i < 4; i++) begin
         sendByte(w[31 - 8*i -: 8]);
         if (gap) begin
            ByteValid = 1'b0;
            @(posedge Clk); #1;
         end
      end
   endtask

   task automatic waitDone(output int doneCyc, output logic errDone);
      int n;
      n = 0;
      @(negedge Clk);
      while (!aDone && n < 3000) begin
         n++;
         @(negedge Clk);
      end
      chk("done_seen", 32'(aDone), 32'd1);
      doneCyc = cyc;
      errDone = aChecksumErr;
      chk("cpuhold_at_done", 32'(aCpuHold), 32'd1);
      @(negedge Clk);
      chk("cpuhold_after_done", 32'(aCpuHold), 32'd0);
      chk("busy_after_done", 32'(aBusy), 32'd0);
      @(posedge Clk); #1;
   endtask

   task automatic runLoad(input int n, input bit gap, output int doneCyc, output logic errDone);
      int m;
      logic [31:0] sum;
      sum = 32'h0;
      m = (n > 256) ? 256 : n;
      pulseStart(n);
      for (int i = 0; i < m; i++) begin
         sendWord(words[i], gap);
         sum = sum + words[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendWord(sum, gap);
`endif
      ByteValid = 1'b0;
      waitDone(doneCyc, errDone);
   endtask

   initial begin
      // reset values
      #2;
      chk("rst_bytereadу", 32'(aByteReady), 32'd0);
      chk("rst_memwrite", 32'(aMemWrite), 32'd0);
      chk("rst_memaddr", aMemAddress, 32'h0);
      chk("rst_memdata", aMemWriteData, 32'h0);
      chk("rst_cpuhold", 32'(aCpuHold), 32'd0);
      chk("rst_busy", 32'(aBusy), 32'd0);
      chk("rst_done", 32'(aDone), 32'd0);
      chk("rst_cksumerr", 32'(aChecksumErr), 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(posedge Clk); #1;

      // reset in the middle of a word discards the partial bytes
      pulseStart(1);
      sendByte(8'hAA);
      sendByte(8'hBB);
      ByteValid = 1'b0;
      chk("midload_busy", 32'(aBusy), 32'd1);
      #2 Reset = 1'b1;
      #1;
      chk("async_rst_busy", 32'(aBusy), 32'd0);
      chk("async_rst_ready", 32'(aByteReady), 32'd0);
      chk("async_rst_hold", 32'(aCpuHold), 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(posedge Clk); #1;
      clearLog();
      words = '{32'h8C01_0004};
      runLoad(1, 1'b0, dCyc, errAtDone);
      chk("w1_count", 32'(aAddrQ.size()), 32'd1);
      chk("w1_addr", aAddrQ[0], 32'h0000_0000);
      chk("w1_data", aDataQ[0], 32'h8C01_0004);
      chk("w1_hold_addr", aMemAddress, 32'h0000_0000);
      chk("w1_hold_data", aMemWriteData, 32'h8C01_0004);
      chk("w1_done_count", 32'(doneCount), 32'd1);

      // three contiguous words
      clearLog();
      words = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
      runLoad(3, 1'b0, dCyc, errAtDone);
      chk("c3_count", 32'(aAddrQ.size()), 32'd3);
      chk("c3_addr0", aAddrQ[0], 32'h0000_0000);
      chk("c3_addr1", aAddrQ[1], 32'h0000_0004);
      chk("c3_addr2", aAddrQ[2], 32'h0000_0008);
      chk("c3_data0", aDataQ[0], 32'h1122_3344);
      chk("c3_data1", aDataQ[1], 32'h5566_7788);
      chk("c3_data2", aDataQ[2], 32'h99AA_BBCC);
      chk("c3_word_spacing", 32'(aCycQ[1] - aCycQ[0]), 32'd5);
`ifndef IMEM_LOADER_CHECKSUM_EN
      chk("c3_done_after_write", 32'(dCyc - aCycQ[2]), 32'd1);
`endif
      chk("c3_done_count", 32'(doneCount), 32'd1);
      chk("wrap_count", 32'(bAddrQ.size()), 32'd3);
      chk("wrap_addr0", bAddrQ[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", bAddrQ[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", bAddrQ[2], 32'h0000_0000);

      // same load with ByteValid toggling, Start re-pulsed mid-LOAD
      clearLog();
      pulseStart(3);
      sendByte(8'h11);
      ByteValid = 1'b0;
      @(posedge Clk); #1;
      sendByte(8'h22);
      ByteValid = 1'b0;
      Start = 1'b1;
      NumWords = 9'd1;
      @(posedge Clk); #1;
      Start = 1'b0;
      sendByte(8'h33);
      ByteValid = 1'b0;
      @(posedge Clk); #1;
      sendByte(8'h44);
      ByteValid = 1'b0;
      @(posedge Clk); #1;
      sendWord(words[1], 1'b1);
      sendWord(words[2], 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendWord(32'h1122_3344 + 32'h5566_7788 + 32'h99AA_BBCC, 1'b1);
`endif
      ByteValid = 1'b0;
      waitDone(dCyc, errAtDone);
      chk("gap_count", 32'(aAddrQ.size()), 32'd3);
      chk("gap_addr2", aAddrQ[2], 32'h0000_0008);
      chk("gap_data0", aDataQ[0], 32'h1122_3344);
      chk("gap_data1", aDataQ[1], 32'h5566_7788);
      chk("gap_data2", aDataQ[2], 32'h99AA_BBCC);
      chk("gap_ready_in_write", 32'(rdyDuringWr), 32'd0);
      chk("gap_done_count", 32'(doneCount), 32'd1);

      // NumWords = 0
      clearLog();
`ifndef IMEM_LOADER_CHECKSUM_EN
      pulseStart(0);
      @(negedge Clk);
      chk("zero_done_next", 32'(aDone), 32'd1);
      chk("zero_no_write", 32'(aMemWrite), 32'd0);
      @(negedge Clk);
      chk("zero_hold_released", 32'(aCpuHold), 32'd0);
      @(posedge Clk); #1;
`else
      words.delete();
      runLoad(0, 1'b0, dCyc, errAtDone);
      chk("zero_cksum_ok", 32'(errAtDone), 32'd0);
`endif
      chk("zero_write_count", 32'(aAddrQ.size()), 32'd0);
      chk("zero_done_count", 32'(doneCount), 32'd1);

      // oversize request clamps to 256 words
      clearLog();
      words.delete();
      for (int i = 0; i < 256; i++) words.push_back(32'hC0DE_0000 | 32'(i));
      runLoad(300, 1'b0, dCyc, errAtDone);
      chk("clamp_count", 32'(aAddrQ.size()), 32'd256);
      chk("clamp_last_addr", aAddrQ[255], 32'h0000_03FC);
      chk("clamp_last_data", aDataQ[255], 32'hC0DE_00FF);
      chk("clamp_wrap_last", bAddrQ[255], 32'h0000_03F4);
      chk("clamp_cksumerr", 32'(aChecksumErr), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      clearLog();
      pulseStart(2);
      sendWord(32'h1, 1'b0);
      sendWord(32'h2, 1'b0);
      sendWord(32'h3, 1'b0);
      ByteValid = 1'b0;
      waitDone(dCyc, errAtDone);
      chk("cksum_good", 32'(errAtDone), 32'd0);
      pulseStart(2);
      sendWord(32'h1, 1'b0);
      sendWord(32'h2, 1'b0);
      sendWord(32'h4, 1'b0);
      ByteValid = 1'b0;
      waitDone(dCyc, errAtDone);
      chk("cksum_bad", 32'(errAtDone), 32'd1);
      chk("cksum_bad_holds", 32'(aChecksumErr), 32'd1);
      pulseStart(0);
      chk("cksum_clear_on_start", 32'(aChecksumErr), 32'd0);
      sendWord(32'h0, 1'b0);
      ByteValid = 1'b0;
      waitDone(dCyc, errAtDone);
      chk("cksum_zero_ok", 32'(errAtDone), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Write-side counterpart to the pipeline's instruction fetch path: fills instruction memory, which the fetch stage then reads.
- Receives a big-endian byte stream over a valid/ready handshake.
- Assembles the bytes into 32-bit words and issues one-cycle word writes at consecutive PC-style byte addresses.
- Holds the CPU in stall while loading; sits beside InstructionMemory, ahead of the PC/IF stage.

Parameters:
- WORD_ADDR_W, 8, log2 of maximum words loadable (256 words).
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  load request; sampled only in IDLE.
- NumWords  input  WORD_ADDR_W+1  words to load; latched on accepted Start.
- ByteIn  input  8  stream byte.
- ByteValid  input  1  ByteIn valid.
- ByteReady  output  1  loader can accept a byte.
- MemWrite  output  1  instruction-memory write strobe.
- MemAddress  output  32  byte address of the write.
- MemWriteData  output  32  assembled word.
- CpuHold  output  1  stall PC/pipeline while high.
- Busy  output  1  high in any state other than IDLE.
- Done  output  1  one-cycle completion pulse.
- ChecksumErr  output  1  checksum mismatch flag; see Optional Feature.

Behaviour:
- Reset, asynchronous, takes effect immediately regardless of state:
  - State goes to IDLE.
  - Every output is 0; MemAddress and MemWriteData are 32'h0.
  - Byte counter, word index and shift register are cleared; any partial word is discarded.
- States: IDLE, LOAD, WRITE, DONE (plus CHECK when CHECKSUM_EN is defined).
- IDLE:
  - ByteReady=0, CpuHold=0.
  - Start=1 with NumWords>0: latch NumWords, clamped to 2^WORD_ADDR_W; clear counters; go to LOAD.
  - Start=1 with NumWords=0: go directly to DONE.
- LOAD:
  - ByteReady=1, CpuHold=1.
  - A byte transfers on any cycle with ByteValid&&ByteReady.
  - Big-endian packing: first byte goes to [31:24], fourth to [7:0].
  - On the 4th transfer, go to WRITE next cycle.
  - ByteValid gaps are allowed and just extend LOAD.
- WRITE: lasts exactly one cycle.
  - MemWrite=1, MemAddress=BASE_ADDR+(word_idx<<2), MemWriteData=assembled word, ByteReady=0.
  - word_idx increments.
  - If this was word NumWords-1, go to DONE (or CHECK); otherwise go to LOAD.
  - Address is computed mod 2^32.
- DONE: lasts one cycle.
  - Done=1, CpuHold still 1.
  - Next state is IDLE, which releases CpuHold.
- Latency: minimum 5 cycles per word (4 byte cycles + 1 WRITE cycle).
- MemWrite is never asserted outside WRITE.
- MemAddress and MemWriteData hold their last written values outside WRITE.
- Start is ignored in every state except IDLE.
- Busy=1 in every state except IDLE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit running sum (mod 2^32) of all written words is kept.
  - After the last WRITE the loader enters CHECK and accepts 4 further big-endian bytes as the expected sum, with ByteReady=1.
  - It then goes to DONE; ChecksumErr is set if received ≠ computed and holds until the next accepted Start or Reset.
  - A NumWords=0 load still passes through CHECK and expects a checksum of 0.
- Not defined: no CHECK state, no extra bytes consumed, ChecksumErr tied to 0.

Test Plan:
- Reset mid-LOAD after 2 bytes, then Start, NumWords=1, bytes 8C,01,00,04 → single MemWrite, Addr 0x0, Data 32'h8C010004 (stale bytes gone).
- Start, NumWords=3, 12 contiguous bytes → writes at 0x0, 0x4, 0x8, each MemWrite exactly 1 cycle; Done pulses 1 cycle after the 3rd write; CpuHold falls the cycle after Done.
- Same load with ByteValid toggling every other cycle → identical writes and data; no byte dropped or duplicated; ByteReady=0 during WRITE.
- Start, NumWords=0 → Done next cycle, no MemWrite; Start re-pulsed during LOAD → ignored, count unchanged.
- BASE_ADDR=32'hFFFF_FFF8, NumWords=3 → addresses FFFFFFF8, FFFFFFFC, 00000000.
- With IMEM_LOADER_CHECKSUM_EN, words 1, 2 followed by checksum 00000003 → ChecksumErr=0; same words followed by 00000004 → ChecksumErr=1 at Done.
